// File: rtl/bingo_top.sv
// Two-player BINGO: keypad entry of a 16-number board, LFSR or hacked guesses,
// match clearing, 7-segment readout and status LEDs.
module bingo_top #(
   parameter int DEBOUNCE_COUNT = 50000,
   parameter int SHOW_COUNT     = 5000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [2:0] keyboard_cols,
   input  logic [7:0] hack_number,
   input  logic       load_hack,
   input  logic       next,
   output logic [3:0] keyboard_rows,
   output logic [7:0] hex_selcted_number_1,
   output logic [7:0] hex_selcted_number_2,
   output logic [7:0] hex_gessed_number_1,
   output logic [7:0] hex_gessed_number_2,
   output logic [8:0] game_state_leds
);

   typedef enum logic [2:0] {
      S_LOAD    = 3'd0,
      S_IDLE    = 3'd1,
      S_COMPARE = 3'd2,
      S_SHOW    = 3'd3,
      S_END     = 3'd4
   } state_t;

   localparam logic [3:0] KEY_STAR = 4'hA;
   localparam logic [3:0] KEY_HASH = 4'hB;
   localparam logic [3:0] KEY_NONE = 4'hF;

   localparam int         DW      = $clog2(DEBOUNCE_COUNT + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_COUNT - 1);
   localparam int         SW      = $clog2(SHOW_COUNT + 1);
   localparam logic [SW-1:0] SH_LAST = SW'(SHOW_COUNT - 1);

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0: s = 8'h3F;
         4'd1: s = 8'h06;
         4'd2: s = 8'h5B;
         4'd3: s = 8'h4F;
         4'd4: s = 8'h66;
         4'd5: s = 8'h6D;
         4'd6: s = 8'h7D;
         4'd7: s = 8'h07;
         4'd8: s = 8'h7F;
         4'd9: s = 8'h6F;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] bcd_nib(input logic [3:0] n);
      return (n > 4'd9) ? 4'(n - 4'd6) : n;
   endfunction

   // Map the frozen row / closed column to a key code; anything ambiguous is KEY_NONE.
   function automatic logic [3:0] decode_key(input logic [3:0] r, input logic [2:0] c);
      logic [3:0] col_n;
      logic [3:0] code;
      code  = KEY_NONE;
      col_n = 4'd0;
      case (c)
         3'b100:  col_n = 4'd0;
         3'b010:  col_n = 4'd1;
         3'b001:  col_n = 4'd2;
         default: col_n = 4'd3;
      endcase
      if (col_n != 4'd3) begin
         case (r)
            4'b1000: code = 4'(4'd1 + col_n);
            4'b0100: code = 4'(4'd4 + col_n);
            4'b0010: code = 4'(4'd7 + col_n);
            4'b0001: code = (col_n == 4'd0) ? KEY_STAR : (col_n == 4'd1) ? 4'd0 : KEY_HASH;
            default: code = KEY_NONE;
         endcase
      end
      return code;
   endfunction

   // ---------------- keypad scan and debounce ----------------
   logic [6:0]    key_id;
   logic [DW-1:0] stable_cnt;
   logic [DW-1:0] release_cnt;
   logic          locked;
   logic          key_valid;
   logic [3:0]    key_code;

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         keyboard_rows <= 4'b1000;
      end else if (keyboard_cols == 3'b000) begin
         keyboard_rows <= {keyboard_rows[0], keyboard_rows[3:1]};
      end
   end

   // A press fires once; re-arming needs the pad to stay open for the full debounce time.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         key_id      <= '0;
         stable_cnt  <= '0;
         release_cnt <= '0;
         locked      <= 1'b0;
         key_valid   <= 1'b0;
         key_code    <= KEY_NONE;
      end else begin
         key_valid <= 1'b0;
         if (keyboard_cols != 3'b000) begin
            release_cnt <= '0;
            if ({keyboard_rows, keyboard_cols} != key_id) begin
               key_id     <= {keyboard_rows, keyboard_cols};
               stable_cnt <= '0;
            end else if (stable_cnt != DB_LAST) begin
               stable_cnt <= stable_cnt + DW'(1);
            end else if (!locked) begin
               locked    <= 1'b1;
               key_code  <= decode_key(keyboard_rows, keyboard_cols);
               key_valid <= (decode_key(keyboard_rows, keyboard_cols) != KEY_NONE);
            end
         end else begin
            key_id     <= '0;
            stable_cnt <= '0;
            if (release_cnt != DB_LAST) release_cnt <= release_cnt + DW'(1);
            else                        locked      <= 1'b0;
         end
      end
   end

   // ---------------- PRNG ----------------
   logic [7:0] lfsr;
   logic [7:0] prng_bcd;

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) lfsr <= 8'hA5;
      else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign prng_bcd = {bcd_nib(lfsr[7:4]), bcd_nib(lfsr[3:0])};

   // ---------------- game FSM ----------------
   state_t        state;
   logic [7:0]    mem [16];
   logic [4:0]    idx;
   logic [3:0]    tens;
   logic [3:0]    units;
   logic          second;
   logic [7:0]    guess;
   logic [15:0]   game_state;
   logic [3:0]    scan_i;
   logic [SW-1:0] show_cnt;
   logic          start_game;
   logic          endgame;

   // NOTE: the board is a register array, not RAM, because reset must empty it in one step.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state      <= S_LOAD;
         idx        <= '0;
         tens       <= '0;
         units      <= '0;
         second     <= 1'b0;
         guess      <= '0;
         game_state <= '0;
         scan_i     <= '0;
         show_cnt   <= '0;
         start_game <= 1'b0;
         endgame    <= 1'b0;
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      end else begin
         case (state)
            S_LOAD: begin
               if (key_valid) begin
                  if (key_code <= 4'd9) begin
                     if (idx != 5'd16) begin
                        if (!second) begin
                           tens   <= key_code;
                           units  <= 4'd0;
                           second <= 1'b1;
                        end else begin
                           units           <= key_code;
                           mem[idx[3:0]]   <= {tens, key_code};
                           idx             <= idx + 5'd1;
                           second          <= 1'b0;
                        end
                     end
                  end else if (key_code == KEY_STAR) begin
                     tens   <= 4'd0;
                     units  <= 4'd0;
                     second <= 1'b0;
                  end else if (key_code == KEY_HASH && idx == 5'd16) begin
                     start_game <= 1'b1;
                     state      <= S_IDLE;
                  end
               end
            end
            S_IDLE: begin
               if (start_game && next) begin
                  guess  <= load_hack ? hack_number : prng_bcd;
                  scan_i <= '0;
                  state  <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               // A zero guess can never hit, so already-cleared entries stay cleared.
               if (guess != 8'h00 && mem[scan_i] == guess) begin
                  mem[scan_i]        <= 8'h00;
                  game_state[scan_i] <= 1'b1;
               end
               scan_i <= scan_i + 4'd1;
               if (scan_i == 4'd15) begin
                  show_cnt <= '0;
                  state    <= S_SHOW;
               end
            end
            S_SHOW: begin
               if (show_cnt != SH_LAST) begin
                  show_cnt <= show_cnt + SW'(1);
               end else if (&game_state[7:0] || &game_state[15:8]) begin
                  endgame <= 1'b1;
                  state   <= S_END;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_END:   state <= S_END;
            default: state <= S_LOAD;
         endcase
      end
   end

   // ---------------- status outputs ----------------
   logic [3:0] p1_count;
   logic [3:0] p2_count;

   always_comb begin
      p1_count = '0;
      p2_count = '0;
      for (int i = 0; i < 8; i++) begin
         p1_count = p1_count + 4'(game_state[i]);
         p2_count = p2_count + 4'(game_state[i+8]);
      end
   end

   assign game_state_leds      = {endgame, p2_count, p1_count};
   assign hex_selcted_number_1 = seg7(tens);
   assign hex_selcted_number_2 = seg7(units);
   assign hex_gessed_number_1  = seg7(guess[7:4]);
   assign hex_gessed_number_2  = seg7(guess[3:0]);

endmodule

// File: tb/tb_bingo_top.sv
// Directed bench for bingo_top: keypad board entry, hacked and PRNG guesses,
// endgame, simultaneous completion and mid-game reset.
module tb_bingo_top;

   logic       clk = 1'b0;
   logic       rstn;
   logic [2:0] keyboard_cols;
   logic [7:0] hack_number;
   logic       load_hack;
   logic       next;
   logic [3:0] keyboard_rows;
   logic [7:0] hex_selcted_number_1;
   logic [7:0] hex_selcted_number_2;
   logic [7:0] hex_gessed_number_1;
   logic [7:0] hex_gessed_number_2;
   logic [8:0] game_state_leds;

   bingo_top #(.DEBOUNCE_COUNT(20), .SHOW_COUNT(10)) dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .keyboard_cols        (keyboard_cols),
      .hack_number          (hack_number),
      .load_hack            (load_hack),
      .next                 (next),
      .keyboard_rows        (keyboard_rows),
      .hex_selcted_number_1 (hex_selcted_number_1),
      .hex_selcted_number_2 (hex_selcted_number_2),
      .hex_gessed_number_1  (hex_gessed_number_1),
      .hex_gessed_number_2  (hex_gessed_number_2),
      .game_state_leds      (game_state_leds)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- keypad model ----------------
   logic       key_on;
   logic [3:0] key_sel;

   function automatic int key_row(input logic [3:0] k);
      case (k)
         4'd1, 4'd2, 4'd3: return 3;
         4'd4, 4'd5, 4'd6: return 2;
         4'd7, 4'd8, 4'd9: return 1;
         default:          return 0;
      endcase
   endfunction

   function automatic int key_col(input logic [3:0] k);
      case (k)
         4'd1, 4'd4, 4'd7, 4'hA: return 2;
         4'd2, 4'd5, 4'd8, 4'd0: return 1;
         default:                return 0;
      endcase
   endfunction

   always_comb begin
      keyboard_cols = 3'b000;
      if (key_on && keyboard_rows[key_row(key_sel)] === 1'b1)
         keyboard_cols = 3'(1 << key_col(key_sel));
   end

   task automatic press(input logic [3:0] k);
      key_sel = k;
      key_on  = 1'b1;
      repeat (150) @(negedge clk);
      key_on  = 1'b0;
      repeat (150) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  m_lfsr;
   logic [7:0]  m_mem [16];
   logic [15:0] m_gs;
   logic [7:0]  exp_guess;
   logic [7:0]  board [16];

   always @(posedge clk or posedge rstn) begin
      if (rstn) m_lfsr <= 8'hA5;
      else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic logic [3:0] to_bcd(input logic [3:0] n);
      return (n > 4'd9) ? 4'(n - 4'd6) : n;
   endfunction

   function automatic logic [7:0] seg(input logic [3:0] d);
      case (d)
         4'd0: return 8'h3F;  4'd1: return 8'h06;  4'd2: return 8'h5B;
         4'd3: return 8'h4F;  4'd4: return 8'h66;  4'd5: return 8'h6D;
         4'd6: return 8'h7D;  4'd7: return 8'h07;  4'd8: return 8'h7F;
         4'd9: return 8'h6F;  default: return 8'h00;
      endcase
   endfunction

   task automatic do_reset();
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_gs      = '0;
      exp_guess = '0;
   endtask

   task automatic load_board(input string tag);
      for (int i = 0; i < 16; i++) begin
         press(board[i][7:4]);
         press(board[i][3:0]);
         m_mem[i] = board[i];
      end
      for (int i = 0; i < 16; i++) check($sformatf("%s_mem%0d", tag, i), 32'(dut.mem[i]), 32'(m_mem[i]));
      check({tag, "_idx"}, 32'(dut.idx), 32'd16);
   endtask

   // One next pulse; live=0 means the DUT is expected to ignore it.
   task automatic do_guess(input logic use_hack, input logic [7:0] hv, input logic live);
      logic [7:0] g;
      @(negedge clk);
      load_hack   = use_hack;
      hack_number = hv;
      g    = use_hack ? hv : {to_bcd(m_lfsr[7:4]), to_bcd(m_lfsr[3:0])};
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      if (live) begin
         exp_guess = g;
         if (g != 8'h00)
            for (int i = 0; i < 16; i++)
               if (m_mem[i] == g) begin
                  m_mem[i] = 8'h00;
                  m_gs[i]  = 1'b1;
               end
      end
      repeat (40) @(negedge clk);
   endtask

   task automatic check_game(input string tag);
      logic       done;
      logic [3:0] c1, c2;
      c1   = 4'($countones(m_gs[7:0]));
      c2   = 4'($countones(m_gs[15:8]));
      done = (m_gs[7:0] == 8'hFF) || (m_gs[15:8] == 8'hFF);
      check({tag, "_gs"},   32'(dut.game_state), 32'(m_gs));
      check({tag, "_leds"}, 32'(game_state_leds), 32'({done, c2, c1}));
      check({tag, "_fsm"},  32'(dut.state), done ? 32'd4 : 32'd1);
      check({tag, "_hx1"},  32'(hex_gessed_number_1), 32'(seg(exp_guess[7:4])));
      check({tag, "_hx2"},  32'(hex_gessed_number_2), 32'(seg(exp_guess[3:0])));
   endtask

   initial begin
      logic [7:0] acc;
      rstn = 1'b1; key_on = 1'b0; key_sel = 4'd0;
      next = 1'b0; load_hack = 1'b0; hack_number = 8'h00;
      do_reset();
      rstn = 1'b1;
      @(negedge clk);
      check("rst_rows", 32'(keyboard_rows), 32'h8);
      check("rst_leds", 32'(game_state_leds), 32'h0);
      check("rst_sel1", 32'(hex_selcted_number_1), 32'h3F);
      check("rst_sel2", 32'(hex_selcted_number_2), 32'h3F);
      check("rst_gs1",  32'(hex_gessed_number_1), 32'h3F);
      check("rst_gs2",  32'(hex_gessed_number_2), 32'h3F);
      check("rst_fsm",  32'(dut.state), 32'd0);
      rstn = 1'b0;

      // Phase A: board 01..08,11..18, hacked win for player 1
      for (int i = 0; i < 16; i++) board[i] = (i < 8) ? 8'(i + 1) : 8'(8'h11 + i - 8);
      load_board("a");
      check("a_sel1", 32'(hex_selcted_number_1), 32'h06);
      check("a_sel2", 32'(hex_selcted_number_2), 32'h7F);
      press(4'd9); press(4'd9);
      check("full_mem15", 32'(dut.mem[15]), 32'h18);
      check("full_idx",   32'(dut.idx), 32'd16);
      check("full_sel1",  32'(hex_selcted_number_1), 32'h06);
      press(4'hB);
      check("start_game", 32'(dut.start_game), 32'd1);
      check("start_fsm",  32'(dut.state), 32'd1);
      check("start_leds", 32'(game_state_leds), 32'h000);
      do_guess(1'b1, 8'h03, 1'b1);
      check("h03_mem2", 32'(dut.mem[2]), 32'h00);
      check_game("h03");
      for (int i = 1; i <= 8; i++) begin
         do_guess(1'b1, 8'(i), 1'b1);
         check_game($sformatf("h%0d", i));
      end
      check("a_end_leds", 32'(game_state_leds), 32'h108);
      do_guess(1'b1, 8'h09, 1'b0);
      check_game("a_ignored");

      // Phase B: duplicated board, PRNG guesses, zero guess, simultaneous win
      do_reset();
      for (int i = 0; i < 16; i++) board[i] = 8'((i % 8) + 1);
      load_board("b");
      press(4'hB);
      for (int n = 0; n < 10; n++) begin
         do_guess(1'b0, 8'h00, 1'b1);
         check($sformatf("rnd%0d_bcd", n),
               32'((dut.guess[7:4] <= 4'd9) && (dut.guess[3:0] <= 4'd9)), 32'd1);
         check_game($sformatf("rnd%0d", n));
      end
      do_guess(1'b1, 8'h00, 1'b1);
      check_game("zero");
      for (int i = 0; i < 16; i++) check($sformatf("zero_mem%0d", i), 32'(dut.mem[i]), 32'(m_mem[i]));
      for (int i = 1; i <= 8; i++) begin
         do_guess(1'b1, 8'(i), 1'b1);
         check_game($sformatf("b%0d", i));
      end
      check("both_leds", 32'(game_state_leds), 32'h188);

      // Phase C: reset during COMPARE, then partial-entry clear and early '#'
      do_reset();
      for (int i = 0; i < 16; i++) board[i] = (i < 8) ? 8'(i + 1) : 8'(8'h11 + i - 8);
      load_board("c");
      press(4'hB);
      @(negedge clk);
      load_hack = 1'b1; hack_number = 8'h05; next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_fsm", 32'(dut.state), 32'd2);
      rstn = 1'b1;
      @(negedge clk);
      acc = 8'h00;
      for (int i = 0; i < 16; i++) acc = acc | dut.mem[i];
      check("mr_fsm",  32'(dut.state), 32'd0);
      check("mr_idx",  32'(dut.idx), 32'd0);
      check("mr_mem",  32'(acc), 32'd0);
      check("mr_gs",   32'(dut.game_state), 32'd0);
      check("mr_leds", 32'(game_state_leds), 32'd0);
      check("mr_rows", 32'(keyboard_rows), 32'h8);
      check("mr_hx1",  32'(hex_gessed_number_1), 32'h3F);
      rstn = 1'b0;
      press(4'd5);
      check("p5_sel1", 32'(hex_selcted_number_1), 32'h6D);
      check("p5_sel2", 32'(hex_selcted_number_2), 32'h3F);
      press(4'hA);
      check("star_sel1", 32'(hex_selcted_number_1), 32'h3F);
      check("star_idx",  32'(dut.idx), 32'd0);
      press(4'd1); press(4'd2);
      check("e12_mem0", 32'(dut.mem[0]), 32'h12);
      check("e12_idx",  32'(dut.idx), 32'd1);
      check("e12_sel2", 32'(hex_selcted_number_2), 32'h5B);
      press(4'hB);
      check("early_hash_fsm", 32'(dut.state), 32'd0);
      check("early_hash_sg",  32'(dut.start_game), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
